// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU (MEM stage) port, debug/loader port and RAM port.
// master = surrounding pipeline/debugger/RAM, slave = the arbiter itself.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, a starvation counter bounds debug latency.
// Define ARB_PERF_CNT_EN to add the perf_stall_cnt / perf_dbg_grants counters.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [15:0]   perf_dbg_grants
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    DBG_RD
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  starve_q;

  logic              in_idle;
  logic              dbg_win;
  logic              cpu_win;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  always_comb begin
    in_idle = (state_q == IDLE);
    dbg_win = in_idle && bus.dbg_req && (!bus.cpu_req || (starve_q == STARVE_LIM));
    cpu_win = in_idle && !dbg_win && bus.cpu_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dbg_win && !bus.dbg_we) begin
            state_q <= DBG_RD;
          end else if (cpu_win && !bus.cpu_we) begin
            state_q <= CPU_RD;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Counts every cycle a pending debug request is not granted, read-return cycles included.
      if (!bus.dbg_req || dbg_win) begin
        starve_q <= '0;
      end else if (starve_q != STARVE_LIM) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

  // Outputs are decoded from state and live inputs, forced to zero while reset is held.
  always_comb begin
    addr_mux       = '0;
    wdata_mux      = '0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.dbg_ack    = 1'b0;
    bus.cpu_rdata  = '0;
    bus.dbg_rdata  = '0;
    bus.cpu_stall  = 1'b0;
    if (!reset) begin
      if (dbg_win) begin
        bus.mem_en  = 1'b1;
        bus.mem_we  = bus.dbg_we;
        addr_mux    = bus.dbg_addr;
        wdata_mux   = bus.dbg_wdata;
        bus.dbg_ack = bus.dbg_we;
      end else if (cpu_win) begin
        bus.mem_en  = 1'b1;
        bus.mem_we  = bus.cpu_we;
        addr_mux    = bus.cpu_addr;
        wdata_mux   = bus.cpu_wdata;
      end

      case (state_q)
        CPU_RD: bus.cpu_rdata = bus.mem_rdata;
        DBG_RD: begin
          bus.dbg_rdata = bus.mem_rdata;
          bus.dbg_ack   = 1'b1;
        end
        default: ;
      endcase

      bus.cpu_stall = bus.cpu_req &&
                      ((in_idle && !(cpu_win && bus.cpu_we)) || (state_q == DBG_RD));
    end
    bus.mem_addr  = addr_mux;
    bus.mem_wdata = wdata_mux;
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] grant_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      if (bus.cpu_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (dbg_win && (grant_cnt_q != '1)) begin
        grant_cnt_q <= grant_cnt_q + 16'd1;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_dbg_grants = grant_cnt_q;
`endif

endmodule
